l2_reqs_param: RTL
==================

Name: l2_reqs_param

Overview:
Parametrised L2 outstanding-request buffer (MSHR) that replaces the fixed-depth request table.
- Holds up to N_REQS in-flight CPU requests, each with set, tag, unstable state, invack counter and opaque payload.
- Provides allocation with backpressure, set-conflict detection, address lookup, forward-stall decision and invack countdown with completion pulse.
- Sits between the L2 controller FSM and the L2 tag/data arrays.

Parameters:
N_REQS, 4, buffer depth (>=2).
SET_BITS, 8, set index width.
TAG_BITS, 20, tag width.
STATE_BITS, 4, unstable-state width.
INV_BITS, 5, invack counter width (unsigned).
PAYLOAD_BITS, 128, opaque per-entry payload (cpu_msg, hsize, hprot, way, offsets, word, amo).
ISD_STATE, 4'd1, encoding of ISD.
MIA_STATE, 4'd5, encoding of MIA.
IDX_BITS, max(1,$clog2(N_REQS)), derived; not overridable.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
alloc_valid  in  1  allocate request
alloc_ready  out  1  free entry exists (= !full)
alloc_set  in  SET_BITS  set of new request; also the conflict-check address
alloc_tag  in  TAG_BITS  tag of new request
alloc_state  in  STATE_BITS  initial state
alloc_payload  in  PAYLOAD_BITS  payload
alloc_idx  out  IDX_BITS  index to be granted (lowest free)
set_conflict  out  1  valid entry has set == alloc_set (combinational)
st_we  in  1  state write
st_idx  in  IDX_BITS  state write index
st_data  in  STATE_BITS  new state
dealloc_valid  in  1  free entry
dealloc_idx  in  IDX_BITS  entry to free
inv_set_valid  in  1  load invack count
inv_set_idx  in  IDX_BITS  target entry
inv_set_cnt  in  INV_BITS  count value
inv_dec_valid  in  1  one invack received
inv_dec_idx  in  IDX_BITS  target entry
inv_done  out  1  registered pulse: counter reached 0
inv_done_idx  out  IDX_BITS  entry whose counter reached 0
lkp_valid  in  1  lookup / fwd peek request
lkp_is_fwd  in  1  1 = fwd peek, 0 = plain lookup
lkp_fwd_inv  in  1  fwd message is FWD_INV/FWD_INV_LLC
lkp_set  in  SET_BITS  lookup set
lkp_tag  in  TAG_BITS  lookup tag
lkp_rsp_valid  out  1  lookup result valid (1 cycle after lkp_valid)
lkp_hit  out  1  registered hit
lkp_idx  out  IDX_BITS  registered hit index
fwd_stall  out  1  registered stall decision
rd_idx  in  IDX_BITS  read-port index
rd_valid, rd_state, rd_set, rd_tag, rd_inv_cnt, rd_payload  out  1/STATE_BITS/SET_BITS/TAG_BITS/INV_BITS/PAYLOAD_BITS  combinational entry read
occupancy  out  IDX_BITS+1  valid-entry count (registered)
empty  out  1  occupancy == 0

Behaviour:
- Reset (rst high at posedge): all valid bits, states, counters and payloads cleared to 0. occupancy=0, empty=1, alloc_ready=1, alloc_idx=0, lkp_rsp_valid=0, lkp_hit=0, lkp_idx=0, fwd_stall=0, inv_done=0, inv_done_idx=0. A reset mid-operation discards all entries. Inputs sampled in the reset cycle are ignored.
- Allocation:
  - Fires when alloc_valid && alloc_ready.
  - Entry alloc_idx takes set, tag, state and payload at the next edge. Valid bit set; inv_cnt = 0.
  - alloc_idx is the lowest-index invalid entry. When full it holds 0 and is ignored.
- set_conflict: combinational over valid entries only, pre-edge contents.
- Dealloc: clears the valid bit next edge. Dealloc of an invalid entry is a no-op (occupancy unchanged).
- Alloc and dealloc in the same cycle:
  - occupancy unchanged.
  - When full, alloc_ready=0 that cycle, so the alloc is refused; the caller retries.
  - alloc_idx never equals dealloc_idx.
- st_we: overwrites the state of a valid entry; ignored on an invalid entry. st_we on the same index as an alloc cannot occur (free entry).
- Invack counter:
  - inv_set loads inv_set_cnt.
  - inv_dec decrements, saturating at 0.
  - Same idx, same cycle: result = inv_set_cnt-1, saturating.
  - inv_done pulses for 1 cycle (next edge) when the counter goes to 0 from nonzero via dec, or when set with value 0. The set-to-0 case yields a pulse, not a dec.
  - Different-index set/dec in one cycle: both apply. If both reach 0, the dec index wins the pulse and the set index pulses the following cycle.
- Lookup (1-cycle latency):
  - Hit = valid && set match && tag match. Multiple hits resolve to the lowest index.
  - Results registered; lkp_rsp_valid=1 exactly one cycle after lkp_valid.
  - Outputs hold their value when lkp_valid=0; only lkp_rsp_valid drops.
  - Lookup sees pre-edge contents, so an alloc in the same cycle is not visible.
- fwd_stall (lkp_is_fwd=1), registered with hit:
  - hit && (lkp_fwd_inv ? state==ISD_STATE : state!=MIA_STATE).
  - Miss gives 0. Plain lookup gives fwd_stall=0.
- occupancy/empty/alloc_ready: derived from valid bits and registered alongside them. alloc_ready = (occupancy != N_REQS).

Decomposition:
- ISD/MIA/INVALID encodings, reqs entry struct and L2 widths come from cache_consts.svh / cache_types.svh. Parameters default from those.
- One sub-module: l2_reqs_prio_enc (parametrised lowest-set-bit encoder with found flag). Used for free-entry selection and hit selection.

Test Plan:
- Fill/backpressure: N_REQS=4, alloc 4 requests -> alloc_idx 0,1,2,3; occupancy=4; alloc_ready=0; 5th alloc refused. Dealloc idx 2 -> next alloc gets idx 2.
- Set conflict: entry set=0x12 valid, alloc_set=0x12 -> set_conflict=1; after dealloc -> 0.
- Lookup: entries 1 and 3 with set 0x05 tag 0xABC -> lkp_hit=1, lkp_idx=1 one cycle later. A miss gives lkp_hit=0.
- Fwd stall: entry in ISD, FWD_INV -> fwd_stall=1. Entry in MIA, FWD_GETS -> 0. Entry in ISD, FWD_GETS -> 1.
- Invack: set cnt=2, then dec, dec -> inv_done pulse once on the 2nd dec edge. Extra dec stays 0 with no pulse. Simultaneous set=3/dec on the same idx -> cnt=2.
- Reset mid-run: 3 entries valid, pending lookup, rst=1 for one cycle -> occupancy=0, empty=1, lkp_rsp_valid=0.

Source files
------------

// File: rtl/l2_reqs_param_pkg.sv
// Shared L2 widths, unstable-state encodings and index-width helper for the request buffer.
// Pure declarations: no logic, no latency, no backpressure.
package l2_reqs_param_pkg;

  localparam int unsigned L2_N_REQS       = 4;
  localparam int unsigned L2_SET_BITS     = 8;
  localparam int unsigned L2_TAG_BITS     = 20;
  localparam int unsigned L2_STATE_BITS   = 4;
  localparam int unsigned L2_INV_BITS     = 5;
  localparam int unsigned L2_PAYLOAD_BITS = 128;

  localparam logic [3:0] INVALID_ENC = 4'd0;
  localparam logic [3:0] ISD_ENC     = 4'd1;
  localparam logic [3:0] MIA_ENC     = 4'd5;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_reqs_prio_enc.sv
// Lowest-set-bit encoder with found flag; idx is 0 when nothing is set.
// Combinational, no backpressure.
module l2_reqs_prio_enc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_reqs_param.sv
// L2 outstanding-request buffer: alloc/dealloc, set conflict, lookup, fwd-stall, invack countdown.
// Lookup and inv_done are 1-cycle registered; alloc is refused (alloc_ready=0) while full.
module l2_reqs_param
  import l2_reqs_param_pkg::*;
#(
  parameter int unsigned N_REQS       = L2_N_REQS,
  parameter int unsigned SET_BITS     = L2_SET_BITS,
  parameter int unsigned TAG_BITS     = L2_TAG_BITS,
  parameter int unsigned STATE_BITS   = L2_STATE_BITS,
  parameter int unsigned INV_BITS     = L2_INV_BITS,
  parameter int unsigned PAYLOAD_BITS = L2_PAYLOAD_BITS,
  parameter logic [STATE_BITS-1:0] ISD_STATE = STATE_BITS'(ISD_ENC),
  parameter logic [STATE_BITS-1:0] MIA_STATE = STATE_BITS'(MIA_ENC),
  localparam int unsigned IDX_BITS = idx_bits(N_REQS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [SET_BITS-1:0]     alloc_set,
  input  logic [TAG_BITS-1:0]     alloc_tag,
  input  logic [STATE_BITS-1:0]   alloc_state,
  input  logic [PAYLOAD_BITS-1:0] alloc_payload,
  output logic [IDX_BITS-1:0]     alloc_idx,
  output logic                    set_conflict,
  input  logic                    st_we,
  input  logic [IDX_BITS-1:0]     st_idx,
  input  logic [STATE_BITS-1:0]   st_data,
  input  logic                    dealloc_valid,
  input  logic [IDX_BITS-1:0]     dealloc_idx,
  input  logic                    inv_set_valid,
  input  logic [IDX_BITS-1:0]     inv_set_idx,
  input  logic [INV_BITS-1:0]     inv_set_cnt,
  input  logic                    inv_dec_valid,
  input  logic [IDX_BITS-1:0]     inv_dec_idx,
  output logic                    inv_done,
  output logic [IDX_BITS-1:0]     inv_done_idx,
  input  logic                    lkp_valid,
  input  logic                    lkp_is_fwd,
  input  logic                    lkp_fwd_inv,
  input  logic [SET_BITS-1:0]     lkp_set,
  input  logic [TAG_BITS-1:0]     lkp_tag,
  output logic                    lkp_rsp_valid,
  output logic                    lkp_hit,
  output logic [IDX_BITS-1:0]     lkp_idx,
  output logic                    fwd_stall,
  input  logic [IDX_BITS-1:0]     rd_idx,
  output logic                    rd_valid,
  output logic [STATE_BITS-1:0]   rd_state,
  output logic [SET_BITS-1:0]     rd_set,
  output logic [TAG_BITS-1:0]     rd_tag,
  output logic [INV_BITS-1:0]     rd_inv_cnt,
  output logic [PAYLOAD_BITS-1:0] rd_payload,
  output logic [IDX_BITS:0]       occupancy,
  output logic                    empty
);

  typedef struct packed {
    logic                    vld;
    logic [STATE_BITS-1:0]   state;
    logic [SET_BITS-1:0]     set;
    logic [TAG_BITS-1:0]     tag;
    logic [INV_BITS-1:0]     inv;
    logic [PAYLOAD_BITS-1:0] payload;
  } entry_t;

  entry_t              ent_q [N_REQS];
  entry_t              ent_d [N_REQS];
  logic [IDX_BITS:0]   occ_q, occ_d;
  logic                lkp_rsp_vld_q, lkp_rsp_vld_d;
  logic                lkp_hit_q, lkp_hit_d;
  logic [IDX_BITS-1:0] lkp_idx_q, lkp_idx_d;
  logic                fwd_stall_q, fwd_stall_d;
  logic                inv_done_q, inv_done_d;
  logic [IDX_BITS-1:0] inv_done_idx_q, inv_done_idx_d;
  logic                pend_vld_q, pend_vld_d;
  logic [IDX_BITS-1:0] pend_idx_q, pend_idx_d;

  logic [N_REQS-1:0]   free_vec, hit_vec, conf_vec;
  logic [IDX_BITS-1:0] free_idx, hit_idx;
  logic                free_found, hit_found;
  logic                alloc_fire;
  logic                dec_ev, set_ev;
  logic                same_idx;

  always_comb begin
    for (int i = 0; i < N_REQS; i++) begin
      free_vec[i] = !ent_q[i].vld;
      hit_vec[i]  = ent_q[i].vld && (ent_q[i].set == lkp_set) && (ent_q[i].tag == lkp_tag);
      conf_vec[i] = ent_q[i].vld && (ent_q[i].set == alloc_set);
    end
  end

  l2_reqs_prio_enc #(.WIDTH(N_REQS), .IDX_W(IDX_BITS)) u_free_enc (
    .req(free_vec), .idx(free_idx), .found(free_found)
  );

  l2_reqs_prio_enc #(.WIDTH(N_REQS), .IDX_W(IDX_BITS)) u_hit_enc (
    .req(hit_vec), .idx(hit_idx), .found(hit_found)
  );

  assign alloc_ready  = (occ_q != (IDX_BITS+1)'(N_REQS));
  assign alloc_idx    = free_found ? free_idx : '0;
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign set_conflict = |conf_vec;
  assign same_idx     = inv_set_valid && inv_dec_valid && (inv_set_idx == inv_dec_idx);

  always_comb begin
    ent_d  = ent_q;
    dec_ev = 1'b0;
    set_ev = 1'b0;
    if (dealloc_valid) ent_d[dealloc_idx].vld = 1'b0;
    if (st_we && ent_q[st_idx].vld) ent_d[st_idx].state = st_data;
    // Same-index set+dec collapses to one load of cnt-1; a zero result is reported as a set event.
    if (same_idx) begin
      ent_d[inv_set_idx].inv = (inv_set_cnt == '0) ? '0 : inv_set_cnt - 1'b1;
      set_ev = (inv_set_cnt <= INV_BITS'(1));
    end else begin
      if (inv_set_valid) begin
        ent_d[inv_set_idx].inv = inv_set_cnt;
        set_ev = (inv_set_cnt == '0);
      end
      if (inv_dec_valid) begin
        ent_d[inv_dec_idx].inv = (ent_q[inv_dec_idx].inv == '0) ? '0 : ent_q[inv_dec_idx].inv - 1'b1;
        dec_ev = (ent_q[inv_dec_idx].inv == INV_BITS'(1));
      end
    end
    if (alloc_fire) begin
      ent_d[alloc_idx] = '{vld: 1'b1, state: alloc_state, set: alloc_set, tag: alloc_tag,
                           inv: '0, payload: alloc_payload};
    end
    occ_d = '0;
    for (int i = 0; i < N_REQS; i++) occ_d = occ_d + {{IDX_BITS{1'b0}}, ent_d[i].vld};
  end

  // One pulse per cycle: dec wins, a displaced set event waits in the pending slot.
  always_comb begin
    inv_done_d     = 1'b0;
    inv_done_idx_d = inv_done_idx_q;
    pend_vld_d     = pend_vld_q;
    pend_idx_d     = pend_idx_q;
    if (dec_ev) begin
      inv_done_d     = 1'b1;
      inv_done_idx_d = inv_dec_idx;
      if (set_ev) begin
        pend_vld_d = 1'b1;
        pend_idx_d = inv_set_idx;
      end
    end else if (set_ev) begin
      inv_done_d     = 1'b1;
      inv_done_idx_d = inv_set_idx;
    end else if (pend_vld_q) begin
      inv_done_d     = 1'b1;
      inv_done_idx_d = pend_idx_q;
      pend_vld_d     = 1'b0;
    end
  end

  always_comb begin
    lkp_rsp_vld_d = lkp_valid;
    lkp_hit_d     = lkp_hit_q;
    lkp_idx_d     = lkp_idx_q;
    fwd_stall_d   = fwd_stall_q;
    if (lkp_valid) begin
      lkp_hit_d   = hit_found;
      lkp_idx_d   = hit_idx;
      fwd_stall_d = lkp_is_fwd && hit_found &&
                    (lkp_fwd_inv ? (ent_q[hit_idx].state == ISD_STATE)
                                 : (ent_q[hit_idx].state != MIA_STATE));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q          <= '{default: '0};
      occ_q          <= '0;
      lkp_rsp_vld_q  <= 1'b0;
      lkp_hit_q      <= 1'b0;
      lkp_idx_q      <= '0;
      fwd_stall_q    <= 1'b0;
      inv_done_q     <= 1'b0;
      inv_done_idx_q <= '0;
      pend_vld_q     <= 1'b0;
      pend_idx_q     <= '0;
    end else begin
      ent_q          <= ent_d;
      occ_q          <= occ_d;
      lkp_rsp_vld_q  <= lkp_rsp_vld_d;
      lkp_hit_q      <= lkp_hit_d;
      lkp_idx_q      <= lkp_idx_d;
      fwd_stall_q    <= fwd_stall_d;
      inv_done_q     <= inv_done_d;
      inv_done_idx_q <= inv_done_idx_d;
      pend_vld_q     <= pend_vld_d;
      pend_idx_q     <= pend_idx_d;
    end
  end

  assign lkp_rsp_valid = lkp_rsp_vld_q;
  assign lkp_hit       = lkp_hit_q;
  assign lkp_idx       = lkp_idx_q;
  assign fwd_stall     = fwd_stall_q;
  assign inv_done      = inv_done_q;
  assign inv_done_idx  = inv_done_idx_q;
  assign occupancy     = occ_q;
  assign empty         = (occ_q == '0);
  assign rd_valid      = ent_q[rd_idx].vld;
  assign rd_state      = ent_q[rd_idx].state;
  assign rd_set        = ent_q[rd_idx].set;
  assign rd_tag        = ent_q[rd_idx].tag;
  assign rd_inv_cnt    = ent_q[rd_idx].inv;
  assign rd_payload    = ent_q[rd_idx].payload;

endmodule
